// File: rtl/vid_lock_monitor.sv
// vid_lock_monitor
//   Measures incoming video timing (clocks per line, lines per frame, DE
//   clocks per line, DE lines per frame) and declares lock once the same
//   measurement repeats for LOCK_FRAMES consecutive frames.
//
// Ports
//   clk, rst_n         pixel clock, asynchronous active-low reset
//   i_hs, i_vs, i_de   video timing inputs (sync polarity set by parameters)
//   o_h_total          clocks per line            (13 b)
//   o_v_total          lines per frame            (13 b)
//   o_h_active         DE clocks per line         (12 b)
//   o_v_active         DE lines per frame         (12 b)
//   o_frame_done       1-cycle pulse when a new measurement is presented
//   o_locked           timing stable
//   o_err_cnt          saturating count of lock losses
module vid_lock_monitor #(
  parameter logic HS_POLORY   = 1'b1,
  parameter logic VS_POLORY   = 1'b1,
  parameter int   LOCK_FRAMES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_de,
  output logic [12:0] o_h_total,
  output logic [12:0] o_v_total,
  output logic [11:0] o_h_active,
  output logic [11:0] o_v_active,
  output logic        o_frame_done,
  output logic        o_locked,
  output logic [7:0]  o_err_cnt
);

  typedef enum logic [1:0] {IDLE, MEASURE, CHECK, LOCKED} state_e;

  typedef struct packed {
    logic [12:0] h_tot;
    logic [11:0] h_act;
    logic [12:0] v_tot;
    logic [11:0] v_act;
  } meas_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  // edge detect
  logic hs_q, vs_q;
  logic line_edge, frame_edge, line_de, timeout;

  // per-line / per-frame counters
  logic [12:0] h_cnt_q, h_cnt_d;
  logic [11:0] de_cnt_q, de_cnt_d;
  logic [12:0] h_tot_q, h_tot_d;
  logic [11:0] h_act_q, h_act_d;
  logic [11:0] v_act_q, v_act_d;
  logic [12:0] v_cnt_q, v_cnt_d;
  logic [12:0] to_cnt_q, to_cnt_d;

  // lock tracking
  state_e      state_q, state_d;
  meas_t       ref_q, ref_d, out_q, out_d, meas;
  logic [3:0]  mc_q, mc_d, mc_inc;
  logic        locked_q, locked_d, done_q, done_d;
  logic [7:0]  err_q, err_d, err_inc;
  logic        meas_sat, meas_ok;

  assign line_edge  = (i_hs == HS_POLORY) && (hs_q != HS_POLORY);
  assign frame_edge = (i_vs == VS_POLORY) && (vs_q != VS_POLORY);
  // a line closing on this edge with DE activity
  assign line_de    = line_edge && (de_cnt_q != '0);
  // 8192th line edge since the last frame edge
  assign timeout    = line_edge && !frame_edge && (&to_cnt_q);

  // The measurement latched at a frame edge is what was accumulated before
  // this cycle; a line edge in the same cycle starts line 1 of the new frame,
  // so its effects go to the fresh counters.
  assign meas     = {h_tot_q, h_act_q, v_cnt_q, v_act_q};
  assign meas_sat = (&h_tot_q) | (&h_act_q) | (&v_cnt_q) | (&v_act_q);
  assign meas_ok  = !meas_sat && (meas == ref_q);
  assign mc_inc   = mc_q + 4'd1;
  assign err_inc  = (&err_q) ? err_q : err_q + 8'd1;

  always_comb begin
    h_cnt_d  = h_cnt_q;
    de_cnt_d = de_cnt_q;
    h_tot_d  = h_tot_q;
    h_act_d  = h_act_q;
    v_act_d  = v_act_q;
    v_cnt_d  = v_cnt_q;
    to_cnt_d = to_cnt_q;
    if (line_edge) begin
      h_cnt_d  = 13'd1;
      de_cnt_d = {11'd0, i_de};
      h_tot_d  = h_cnt_q;
    end else begin
      if (!(&h_cnt_q))          h_cnt_d  = h_cnt_q + 13'd1;
      if (i_de && !(&de_cnt_q)) de_cnt_d = de_cnt_q + 12'd1;
    end
    if (frame_edge) begin
      v_cnt_d  = line_edge ? 13'd1 : 13'd0;
      v_act_d  = line_de ? 12'd1 : 12'd0;
      h_act_d  = line_de ? de_cnt_q : 12'd0;
      to_cnt_d = '0;
    end else begin
      if (line_edge && !(&v_cnt_q)) v_cnt_d = v_cnt_q + 13'd1;
      if (line_de) begin
        h_act_d = de_cnt_q;
        if (!(&v_act_q)) v_act_d = v_act_q + 12'd1;
      end
      // wraps to zero on the timeout edge, re-arming the watchdog
      if (line_edge) to_cnt_d = to_cnt_q + 13'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    mc_d     = mc_q;
    locked_d = locked_q;
    err_d    = err_q;
    out_d    = out_q;
    done_d   = 1'b0;
    if (frame_edge) begin
      // the partial frame seen from IDLE is never reported
      if (state_q != IDLE) begin
        out_d  = meas;
        done_d = 1'b1;
      end
      case (state_q)
        IDLE:    state_d = MEASURE;
        MEASURE: begin
          ref_d   = meas;
          mc_d    = '0;
          state_d = CHECK;
        end
        CHECK: begin
          if (meas_ok) begin
            mc_d = mc_inc;
            if (mc_inc == LOCK_N) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            ref_d = meas;
            mc_d  = '0;
          end
        end
        LOCKED: begin
          if (!meas_ok) begin
            locked_d = 1'b0;
            err_d    = err_inc;
            ref_d    = meas;
            mc_d     = '0;
            state_d  = CHECK;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d  = IDLE;
      locked_d = 1'b0;
      mc_d     = '0;
      if (state_q == LOCKED) err_d = err_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q     <= ~HS_POLORY;
      vs_q     <= ~VS_POLORY;
      h_cnt_q  <= '0;
      de_cnt_q <= '0;
      h_tot_q  <= '0;
      h_act_q  <= '0;
      v_act_q  <= '0;
      v_cnt_q  <= '0;
      to_cnt_q <= '0;
      state_q  <= IDLE;
      ref_q    <= '0;
      out_q    <= '0;
      mc_q     <= '0;
      locked_q <= 1'b0;
      err_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      hs_q     <= i_hs;
      vs_q     <= i_vs;
      h_cnt_q  <= h_cnt_d;
      de_cnt_q <= de_cnt_d;
      h_tot_q  <= h_tot_d;
      h_act_q  <= h_act_d;
      v_act_q  <= v_act_d;
      v_cnt_q  <= v_cnt_d;
      to_cnt_q <= to_cnt_d;
      state_q  <= state_d;
      ref_q    <= ref_d;
      out_q    <= out_d;
      mc_q     <= mc_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign o_h_total    = out_q.h_tot;
  assign o_h_active   = out_q.h_act;
  assign o_v_total    = out_q.v_tot;
  assign o_v_active   = out_q.v_act;
  assign o_frame_done = done_q;
  assign o_locked     = locked_q;
  assign o_err_cnt    = err_q;

endmodule

// File: tb/tb_vid_lock_monitor.sv
// Bench for vid_lock_monitor: a frame-level reference model predicts each
// reported measurement; monitors on two instances (active-high and
// active-low syncs) pop and compare on every o_frame_done.
module tb_vid_lock_monitor;

  logic clk = 1'b0;
  logic rst_n, hs, vs, de;
  always #5 clk = ~clk;

  logic [12:0] a_ht, a_vt, b_ht, b_vt;
  logic [11:0] a_ha, a_va, b_ha, b_va;
  logic        a_done, a_lk, b_done, b_lk;
  logic [7:0]  a_err, b_err;

  vid_lock_monitor #(.HS_POLORY(1'b1), .VS_POLORY(1'b1), .LOCK_FRAMES(3)) dut_p (
    .clk(clk), .rst_n(rst_n), .i_hs(hs), .i_vs(vs), .i_de(de),
    .o_h_total(a_ht), .o_v_total(a_vt), .o_h_active(a_ha), .o_v_active(a_va),
    .o_frame_done(a_done), .o_locked(a_lk), .o_err_cnt(a_err));

  vid_lock_monitor #(.HS_POLORY(1'b0), .VS_POLORY(1'b0), .LOCK_FRAMES(3)) dut_n (
    .clk(clk), .rst_n(rst_n), .i_hs(~hs), .i_vs(~vs), .i_de(de),
    .o_h_total(b_ht), .o_v_total(b_vt), .o_h_active(b_ha), .o_v_active(b_va),
    .o_frame_done(b_done), .o_locked(b_lk), .o_err_cnt(b_err));

  logic [58:0] act_a, act_b, exp_a, exp_b;
  assign act_a = {a_ht, a_ha, a_vt, a_va, a_lk, a_err};
  assign act_b = {b_ht, b_ha, b_vt, b_va, b_lk, b_err};

  int checks = 0;
  int errors = 0;

  typedef struct {
    int hsp, hbp, hv, hfp, vsp, vbp, vv, vfp;
  } tim_t;

  function automatic int htot(tim_t t); return t.hsp + t.hbp + t.hv + t.hfp; endfunction
  function automatic int vtot(tim_t t); return t.vsp + t.vbp + t.vv + t.vfp; endfunction

  // ---------------- reference model (one step per frame edge) ----------
  localparam int M_IDLE = 0, M_MEAS = 1, M_CHECK = 2, M_LOCK = 3;
  int          m_st, m_mc, m_err;
  logic        m_locked;
  logic [49:0] m_ref;
  logic [58:0] q_a[$], q_b[$];
  tim_t        prev_t;

  function automatic logic [49:0] meas_of(tim_t t);
    return {13'(htot(t)), 12'(t.hv), 13'(vtot(t)), 12'(t.vv)};
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_mc = 0; m_err = 0; m_locked = 1'b0; m_ref = '0;
    q_a.delete(); q_b.delete();
  endtask

  // p is the frame that just ended
  task automatic model_fe(input tim_t p);
    logic [49:0] m;
    m = meas_of(p);
    if (m_st == M_IDLE) begin
      m_st = M_MEAS;
      return;
    end
    if (m_st == M_MEAS) begin
      m_ref = m; m_mc = 0; m_st = M_CHECK;
    end else if (m_st == M_CHECK) begin
      if (m == m_ref) begin
        m_mc++;
        if (m_mc == 3) begin m_st = M_LOCK; m_locked = 1'b1; end
      end else begin
        m_ref = m; m_mc = 0;
      end
    end else if (m != m_ref) begin
      m_locked = 1'b0;
      m_err = (m_err < 255) ? m_err + 1 : 255;
      m_ref = m; m_mc = 0; m_st = M_CHECK;
    end
    q_a.push_back({m, m_locked, 8'(m_err)});
    q_b.push_back({m, m_locked, 8'(m_err)});
  endtask

  task automatic model_timeout();
    if (m_st == M_LOCK) m_err = (m_err < 255) ? m_err + 1 : 255;
    m_st = M_IDLE; m_locked = 1'b0; m_mc = 0;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n && a_done) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL done_p_spurious got=%h exp=no_pulse", act_a);
      end else begin
        exp_a = q_a.pop_front();
        if (act_a !== exp_a) begin
          errors++;
          $display("FAIL done_p got=%h exp=%h", act_a, exp_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_done) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL done_n_spurious got=%h exp=no_pulse", act_b);
      end else begin
        exp_b = q_b.pop_front();
        if (act_b !== exp_b) begin
          errors++;
          $display("FAIL done_n got=%h exp=%h", act_b, exp_b);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic drive_cycle(input logic h, input logic v, input logic d);
    @(negedge clk);
    hs = h; vs = v; de = d;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_zero_p", 64'({act_a, a_done}), 64'd0);
    chk("rst_zero_n", 64'({act_b, b_done}), 64'd0);
    chk("rst_pending", 64'(q_a.size() + q_b.size()), 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // rst_line >= 0 pulses reset in the middle of that line's active region
  task automatic drive_frame(input tim_t t, input int rst_line);
    model_fe(prev_t);
    prev_t = t;
    for (int l = 0; l < vtot(t); l++) begin
      for (int x = 0; x < htot(t); x++) begin
        drive_cycle(x < t.hsp, l < t.vsp,
                    (l >= t.vsp + t.vbp) && (l < t.vsp + t.vbp + t.vv) &&
                    (x >= t.hsp + t.hbp) && (x < t.hsp + t.hbp + t.hv));
        if (l == rst_line && x == t.hsp + t.hbp + 1) reset_pulse();
      end
    end
  endtask

  function automatic tim_t rand_tim();
    tim_t t;
    t.hsp = int'($urandom_range(3, 1));  t.hbp = int'($urandom_range(4, 1));
    t.hv  = int'($urandom_range(16, 4)); t.hfp = int'($urandom_range(5, 1));
    t.vsp = int'($urandom_range(2, 1));  t.vbp = int'($urandom_range(2, 1));
    t.vv  = int'($urandom_range(8, 2));  t.vfp = int'($urandom_range(3, 1));
    return t;
  endfunction

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tim_t t0, t1, ta, tb, cur;
    int need;
    t0 = '{2, 3, 12, 4, 1, 2, 6, 3};   // 21 x 12
    t1 = t0; t1.hfp = 5;              // one extra front-porch clock
    ta = '{1, 1, 1, 1, 1, 0, 1, 1};   // 4 x 3
    tb = ta; tb.hfp = 2;              // 5 x 3
    prev_t = t0;
    model_reset();
    rst_n = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_p", 64'({act_a, a_done}), 64'd0);
    chk("reset_n", 64'({act_b, b_done}), 64'd0);
    rst_n = 1'b1;

    // stable timing: lock at 4th report
    repeat (8) drive_frame(t0, -1);
    chk("stable_locked", 64'(a_lk), 64'd1);
    chk("stable_htot", 64'(a_ht), 64'd21);

    // one long-porch frame while locked
    drive_frame(t1, -1);
    drive_frame(t0, -1);
    chk("loss_unlocked", 64'(a_lk), 64'd0);
    chk("loss_err", 64'(a_err), 64'd1);
    repeat (4) drive_frame(t0, -1);
    chk("relock", 64'(b_lk), 64'd1);

    // random timing sequences with runs
    cur = t0;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(3, 0) == 0) cur = rand_tim();
      drive_frame(cur, -1);
    end

    // lock, then hold vs inactive
    repeat (6) drive_frame(t0, -1);
    chk("pre_timeout_lock", 64'(a_lk), 64'd1);
    need = 8192 - (vtot(t0) - 1);
    for (int n = 1; n <= 8200; n++) begin
      if (n == need) chk("timeout_early", 64'(a_lk), 64'd1);
      drive_cycle(1'b1, 1'b0, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b0);
      if (n == need) begin
        model_timeout();
        chk("timeout_lock_p", 64'(a_lk), 64'd0);
        chk("timeout_lock_n", 64'(b_lk), 64'd0);
        chk("timeout_err", 64'(a_err), 64'(m_err));
      end
    end

    // reset in frame 5
    repeat (4) drive_frame(t0, -1);
    drive_frame(t0, 6);
    repeat (3) drive_frame(t0, -1);

    // 300 forced lock losses
    repeat (5) drive_frame(ta, -1);
    for (int g = 0; g < 300; g++)
      repeat (4) drive_frame((g % 2 == 0) ? tb : ta, -1);
    drive_frame(ta, -1);
    chk("err_sat_p", 64'(a_err), 64'd255);
    chk("err_sat_n", 64'(b_err), 64'd255);

    repeat (4) @(negedge clk);
    chk("drain_p", 64'(q_a.size()), 64'd0);
    chk("drain_n", 64'(q_b.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
